// File: rtl/freq_pkg.sv
// Shared types and elaboration-time helpers for freq_meter and the clock-divider family.
package freq_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int SYNC_DEPTH_DEFAULT = 2;

  // Number of Clk cycles in one gate window (also used by the divider's terminal-count math).
  function automatic int gate_cycles(input int freq_in, input int rate_hz);
    return freq_in / rate_hz;
  endfunction

  // Width that holds count * mult without truncation.
  function automatic int sat_mul_w(input int count_w, input int mult);
    return count_w + $clog2(mult + 1);
  endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Control/result bundle of freq_meter. Period outputs exist only with FREQ_METER_PERIOD_EN.
interface freq_meter_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   Enable;
  logic                   SignalIn;
  logic [COUNT_WIDTH-1:0] FrequencyOut;
  logic                   Valid;
  logic                   Overflow;
`ifdef FREQ_METER_PERIOD_EN
  logic [COUNT_WIDTH-1:0] PeriodOut;
  logic                   PeriodValid;

  modport master (
    output Enable, SignalIn,
    input  FrequencyOut, Valid, Overflow, PeriodOut, PeriodValid
  );
  modport slave (
    input  Enable, SignalIn,
    output FrequencyOut, Valid, Overflow, PeriodOut, PeriodValid
  );
`else
  modport master (
    output Enable, SignalIn,
    input  FrequencyOut, Valid, Overflow
  );
  modport slave (
    input  Enable, SignalIn,
    output FrequencyOut, Valid, Overflow
  );
`endif
endinterface

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a one-flop rising-edge detector.
module sync_edge_detect #(
  parameter int DEPTH = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [DEPTH-1:0] r_sync;
  logic             r_prev;

  if (DEPTH < 2) begin : g_chk_depth
    $error("sync_edge_detect: DEPTH must be at least 2");
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_async};
      r_prev <= r_sync[DEPTH-1];
    end
  end

  assign o_rise = r_sync[DEPTH-1] & ~r_prev;

endmodule

// File: rtl/freq_meter.sv
// Counts synchronized SignalIn rising edges over a GATE_CYCLES window and reports Hz.
// Optional period measurement is enabled by defining FREQ_METER_PERIOD_EN.
module freq_meter
  import freq_pkg::*;
#(
  parameter int FREQUENCY_IN = 100_000_000,
  parameter int GATE_HZ      = 1,
  parameter int COUNT_WIDTH  = 32
) (
  input logic         Clk,
  input logic         Reset,
  freq_meter_if.slave bus
);

  localparam int GATE_CYCLES = gate_cycles(FREQUENCY_IN, GATE_HZ);
  localparam int GC_W        = $clog2(GATE_CYCLES);
  localparam int PROD_W      = sat_mul_w(COUNT_WIDTH, GATE_HZ);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [GC_W-1:0]        GATE_LAST = GC_W'(GATE_CYCLES - 1);

  if (GATE_CYCLES < 2) begin : g_chk_gate
    $error("freq_meter: gate window must be at least 2 Clk cycles");
  end
  if ($clog2(GATE_HZ + 1) > COUNT_WIDTH) begin : g_chk_fit
    $error("freq_meter: GATE_HZ does not fit in COUNT_WIDTH");
  end

  logic                   w_rise;
  state_e                 r_state;
  state_e                 w_state_nxt;
  logic                   w_gate_end;
  logic                   w_count_en;
  logic [GC_W-1:0]        r_gcnt;
  logic [COUNT_WIDTH-1:0] r_ecnt;
  logic [COUNT_WIDTH-1:0] w_ecnt_tot;
  logic                   r_esat;
  logic                   w_esat_tot;
  logic [PROD_W-1:0]      w_prod;
  logic                   w_ovf;
  logic [COUNT_WIDTH-1:0] r_freq;
  logic                   r_valid;
  logic                   r_ovf;

  sync_edge_detect #(
    .DEPTH (SYNC_DEPTH_DEFAULT)
  ) u_sync (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_async (bus.SignalIn),
    .o_rise  (w_rise)
  );

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Dropping Enable aborts the window before a gate end can be reported.
  always_comb begin
    w_state_nxt = r_state;
    w_gate_end  = 1'b0;
    w_count_en  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.Enable) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        if (!bus.Enable)              w_state_nxt = IDLE;
        else if (r_gcnt == GATE_LAST) w_gate_end  = 1'b1;
        else                          w_count_en  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The edge arriving in the gate-end cycle still belongs to the closing window.
  assign w_ecnt_tot = (r_ecnt == CNT_MAX) ? r_ecnt : r_ecnt + COUNT_WIDTH'(w_rise);
  assign w_esat_tot = r_esat | ((r_ecnt == CNT_MAX) & w_rise);
  assign w_prod     = PROD_W'(w_ecnt_tot) * PROD_W'(GATE_HZ);
  assign w_ovf      = w_esat_tot | (|w_prod[PROD_W-1:COUNT_WIDTH]);

  always_ff @(posedge Clk) begin
    if (Reset || !w_count_en) begin
      r_gcnt <= '0;
      r_ecnt <= '0;
      r_esat <= 1'b0;
    end else begin
      r_gcnt <= r_gcnt + GC_W'(1);
      r_ecnt <= w_ecnt_tot;
      r_esat <= w_esat_tot;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_freq  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= w_gate_end;
      if (w_gate_end) begin
        r_ovf  <= w_ovf;
        r_freq <= w_ovf ? CNT_MAX : w_prod[COUNT_WIDTH-1:0];
      end
    end
  end

  assign bus.FrequencyOut = r_freq;
  assign bus.Valid        = r_valid;
  assign bus.Overflow     = r_ovf;

`ifdef FREQ_METER_PERIOD_EN
  logic                   r_per_armed;
  logic [COUNT_WIDTH-1:0] r_per_cnt;
  logic [COUNT_WIDTH-1:0] r_per_out;
  logic                   r_per_vld;

  // r_per_cnt holds the cycles elapsed since the last edge, so it restarts at 1.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_per_armed <= 1'b0;
      r_per_cnt   <= '0;
      r_per_out   <= '0;
      r_per_vld   <= 1'b0;
    end else if (!bus.Enable) begin
      r_per_armed <= 1'b0;
      r_per_cnt   <= '0;
      r_per_vld   <= 1'b0;
    end else begin
      r_per_vld <= w_rise & r_per_armed;
      if (w_rise) begin
        r_per_armed <= 1'b1;
        r_per_cnt   <= COUNT_WIDTH'(1);
        if (r_per_armed) r_per_out <= r_per_cnt;
      end else if (r_per_cnt != CNT_MAX) begin
        r_per_cnt <= r_per_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.PeriodOut   = r_per_out;
  assign bus.PeriodValid = r_per_vld;
`endif

endmodule
